// File: rtl/uart_rx_if.sv
// uart_rx_if: tick/serial inputs and received-word outputs of the UART receiver.
// Modport slave is the receiver side; master is the driving/observing side.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_tick;
    logic                  rx;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rx_done;
    logic                  frame_err;

    modport master (
        output s_tick,
        output rx,
        input  dout,
        input  rx_done,
        input  frame_err
    );

    modport slave (
        input  s_tick,
        input  rx,
        output dout,
        output rx_done,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 1 start / DATA_WIDTH data (LSB first) / 1 stop.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: data and stop bits are taken as the
// 2-of-3 majority of the samples at ticks 13, 14 and 15 instead of the single tick-15 sample.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic      clk,
    input logic      reset,
    uart_rx_if.slave bus
);
    localparam int unsigned NW = $clog2(DATA_WIDTH) + 1;
    localparam logic [NW-1:0] LAST_BIT = NW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q;
    logic [1:0]            sync_q;
    logic                  rx_s;
    logic [3:0]            s_q;
    logic [NW-1:0]         n_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rx_done_q;
    logic                  frame_err_q;
    logic                  sample_c;

    // Two-flop synchronizer; resets to the idle-high line level so release never fakes a start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rx};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Samples taken at ticks 13 and 14; the tick-15 sample is the live rx_s
    logic [1:0] vote_q;

    // Mid-bit value as the 2-of-3 majority of ticks 13, 14, 15
    assign sample_c = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
    // Mid-bit value as the single tick-15 sample
    assign sample_c = rx_s;
`endif

    // Receive FSM with tick/bit counters, shift register and registered strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote_q      <= '0;
`endif
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_q     <= '0;
                        n_q     <= '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
                        vote_q  <= '0;
`endif
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s_q == 4'd7) begin
                            // A line back high at mid-start is a glitch, not a frame
                            state_q <= rx_s ? IDLE : DATA;
                            s_q     <= '0;
                            n_q     <= '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
                            vote_q  <= '0;
`endif
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s_q == 4'd15) begin
                            b_q <= DATA_WIDTH'({sample_c, b_q} >> 1);
                            s_q <= '0;
                            if (n_q == LAST_BIT) begin
                                state_q <= STOP;
                                n_q     <= '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
                                vote_q  <= '0;
`endif
                            end else begin
                                n_q <= n_q + NW'(1);
                            end
                        end else begin
                            s_q <= s_q + 4'd1;
`ifdef UART_RX_MAJORITY_VOTE_EN
                            if (s_q >= 4'd13) begin
                                vote_q <= {vote_q[0], rx_s};
                            end
`endif
                        end
                    end
                end
                STOP: begin
                    if (bus.s_tick) begin
                        if (s_q == 4'd15) begin
                            // Leave at mid-stop so a following start bit can be caught immediately
                            dout_q      <= b_q;
                            rx_done_q   <= 1'b1;
                            frame_err_q <= ~sample_c;
                            state_q     <= IDLE;
                            s_q         <= '0;
                            n_q         <= '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
                            vote_q      <= '0;
`endif
                        end else begin
                            s_q <= s_q + 4'd1;
`ifdef UART_RX_MAJORITY_VOTE_EN
                            if (s_q >= 4'd13) begin
                                vote_q <= {vote_q[0], rx_s};
                            end
`endif
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; frames are serialized at 16 ticks/bit,
// one s_tick every 4 clk, and received words are matched against the expected queue.
module tb_uart_rx;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          fe;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    rec_t          exp_q[$];
    rec_t          obs_q[$];
    int            n_chk     = 0;
    int            n_fail    = 0;
    int            pulse_err = 0;
    logic [DW-1:0] last_dout = '0;

    // Output monitor: records every rx_done word and counts strobe/hold violations
    logic          prev_done;
    logic [DW-1:0] prev_dout;
    rec_t          mon_r;
    always @(negedge clk) begin
        if (!reset) begin
            prev_done = 1'b0;
            prev_dout = '0;
        end else begin
            if (bus.rx_done === 1'b1) begin
                mon_r.d  = bus.dout;
                mon_r.fe = bus.frame_err;
                obs_q.push_back(mon_r);
            end
            if (bus.rx_done === 1'b1 && prev_done === 1'b1) pulse_err++;
            if (bus.frame_err === 1'b1 && bus.rx_done !== 1'b1) pulse_err++;
            if (bus.rx_done !== 1'b1 && bus.dout !== prev_dout) pulse_err++;
            prev_done = bus.rx_done;
            prev_dout = bus.dout;
        end
    end

    // One 4-clk tick period with s_tick high for the first clk
    task automatic tick_cycle();
        @(negedge clk) bus.s_tick = 1'b1;
        @(negedge clk) bus.s_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int ticks);
        bus.rx = v;
        repeat (ticks) tick_cycle();
    endtask

    // A low stop bit is released right after its mid-bit sample so it is not taken as a new start
    task automatic send_frame(input logic [DW-1:0] d, input logic stop);
        rec_t r;
        r.d  = d;
        r.fe = ~stop;
        exp_q.push_back(r);
        send_bit(1'b0, 16);
        for (int i = 0; i < int'(DW); i++) send_bit(d[i], 16);
        if (stop) begin
            send_bit(1'b1, 16);
        end else begin
            send_bit(1'b0, 8);
            send_bit(1'b1, 8);
        end
    endtask

    task automatic drain(output bit ok);
        int cyc;
        cyc = 0;
        while (obs_q.size() < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        ok = (obs_q.size() >= exp_q.size());
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rx     = 1'b1;
        bus.s_tick = 1'b0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 00", bus.dout); end
        n_chk++;
        if (bus.rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got %b want 0", bus.rx_done); end
        n_chk++;
        if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
        reset = 1'b1;
        send_bit(1'b1, 20);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_release_spurious got %0d words want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_frames(input string name);
        bit   ok;
        rec_t e;
        rec_t o;
        drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout got %0d words want %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            last_dout = e.d;
            n_chk++;
            if (o.d !== e.d) begin n_fail++; $display("FAIL %s_dout got %h want %h", name, o.d, e.d); end
            n_chk++;
            if (o.fe !== e.fe) begin n_fail++; $display("FAIL %s_frame_err got %b want %b", name, o.fe, e.fe); end
        end
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL %s_extra got %0d extra words want 0", name, obs_q.size()); end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1);
        test_frames("basic");
    endtask

    task automatic test_back_to_back();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        test_frames("back_to_back");
    endtask

    task automatic test_framing_error();
        send_frame(8'hFF, 1'b0);
        send_bit(1'b1, 16);
        send_frame(8'h12, 1'b1);
        test_frames("framing");
    endtask

    task automatic test_false_start();
        send_bit(1'b0, 4);
        send_bit(1'b1, 20);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL false_start_done got %0d words want 0", obs_q.size()); end
        n_chk++;
        if (bus.dout !== last_dout) begin n_fail++; $display("FAIL false_start_dout got %h want %h", bus.dout, last_dout); end
        obs_q.delete();
        send_frame(8'h69, 1'b1);
        test_frames("after_false_start");
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d;
        d = 8'hC3;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16);
        send_bit(d[4], 8);
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.dout !== '0) begin n_fail++; $display("FAIL midreset_dout got %h want 00", bus.dout); end
        n_chk++;
        if (bus.rx_done !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_strobes got %b%b want 00", bus.rx_done, bus.frame_err);
        end
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        send_bit(1'b1, 20);
        send_frame(8'h3C, 1'b1);
        test_frames("after_midreset");
    endtask

    // Frame 0x00 with bit 3 high only in the tick period feeding the tick-15 sample
    task automatic test_sampling();
        rec_t r;
`ifdef UART_RX_MAJORITY_VOTE_EN
        r.d = 8'h00;
`else
        r.d = 8'h08;
`endif
        r.fe = 1'b0;
        exp_q.push_back(r);
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 16);
        send_bit(1'b0, 7);
        send_bit(1'b1, 1);
        send_bit(1'b0, 8);
        for (int i = 4; i < int'(DW); i++) send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        test_frames("sampling");
    endtask

    task automatic test_output_hold();
        n_chk++;
        if (pulse_err != 0) begin n_fail++; $display("FAIL output_hold got %0d violations want 0", pulse_err); end
    endtask

    initial begin
        bus.rx     = 1'b1;
        bus.s_tick = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_framing_error();
        test_false_start();
        test_reset_mid_frame();
        test_sampling();
        test_output_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
